hardwired_ctrl: RTL and testbench

Hardwired fetch/decode/execute controller for the simple CPU. It drives the load/increment/clear controls of the 6-bit program counter and the 9-bit accumulator, and computes the data they load. It sequences instruction and operand reads over a ready-handshaked memory port. It sits directly upstream of the PC and AC counters and consumes their STATE outputs.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/alu8.sv | 22 ++
 rtl/hardwired_ctrl.sv | 131 +++++++++++++
 tb/tb_hardwired_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU: datapath widths, opcode encodings
// and the controller state encoding used by the controller and its monitors.
package cpu_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int AC_W   = DATA_W + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CLEAR  = 4'd1,
    FETCH1 = 4'd2,
    FETCH2 = 4'd3,
    DECODE = 4'd4,
    ADD1   = 4'd5,
    ADD2   = 4'd6,
    AND1   = 4'd7,
    AND2   = 4'd8,
    JMP1   = 4'd9,
    INC1   = 4'd10
  } ctrl_state_t;

endpackage

// File: rtl/alu8.sv
// Combinational ALU producing the accumulator load value for ADD and AND.
// ADD keeps the carry in bit 8; AND always clears bit 8.
module alu8
  import cpu_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [AC_W-1:0]   y
);

  // Select the result for the requested opcode; other opcodes give 0
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = {1'b0, a} + {1'b0, b};
      OP_AND:  y = {1'b0, a & b};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/hardwired_ctrl.sv
// Hardwired fetch/decode/execute controller. Sequences instruction and
// operand reads, and drives the PC and AC counter controls. All outputs are
// decoded from the registered state; AC_DATA additionally uses AC_STATE/DR.
module hardwired_ctrl
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] PC_STATE,
  input  logic [AC_W-1:0]   AC_STATE,
  input  logic [DATA_W-1:0] MEM_DATA,
  input  logic              MEM_READY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  output logic              PC_LD,
  output logic              PC_INC,
  output logic              PC_CLR,
  output logic [ADDR_W-1:0] PC_DATA,
  output logic              AC_LD,
  output logic              AC_INC,
  output logic              AC_CLR,
  output logic [AC_W-1:0]   AC_DATA,
  output logic              BUSY
);

  ctrl_state_t       state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] dr_q, dr_d;
  logic [1:0]        alu_op;
  logic [AC_W-1:0]   alu_y;

  // The carry bit of the accumulator never feeds the ADD/AND operands
  logic unused_ac_carry;
  assign unused_ac_carry = AC_STATE[AC_W-1];

  // AND2 is the only state that needs the AND result; everything else adds
  assign alu_op = (state_q == AND2) ? OP_AND : OP_ADD;

  alu8 u_alu (
    .op (alu_op),
    .a  (AC_STATE[DATA_W-1:0]),
    .b  (dr_q),
    .y  (alu_y)
  );

  // Next-state, register capture and Moore output decode
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    dr_d     = dr_q;
    MEM_ADDR = '0;
    MEM_RD   = 1'b0;
    PC_LD    = 1'b0;
    PC_INC   = 1'b0;
    PC_CLR   = 1'b0;
    PC_DATA  = '0;
    AC_LD    = 1'b0;
    AC_INC   = 1'b0;
    AC_CLR   = 1'b0;
    AC_DATA  = '0;
    BUSY     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (START) state_d = CLEAR;
      end
      CLEAR: begin
        PC_CLR  = 1'b1;
        AC_CLR  = 1'b1;
        state_d = FETCH1;
      end
      FETCH1: begin
        MEM_ADDR = PC_STATE;
        MEM_RD   = 1'b1;
        if (MEM_READY) begin
          ir_d    = MEM_DATA;
          state_d = FETCH2;
        end
      end
      FETCH2: begin
        PC_INC  = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        case (ir_q[7:6])
          OP_ADD:  state_d = ADD1;
          OP_AND:  state_d = AND1;
          OP_JMP:  state_d = JMP1;
          default: state_d = INC1;
        endcase
      end
      ADD1, AND1: begin
        MEM_ADDR = ir_q[ADDR_W-1:0];
        MEM_RD   = 1'b1;
        if (MEM_READY) begin
          dr_d    = MEM_DATA;
          state_d = (state_q == ADD1) ? ADD2 : AND2;
        end
      end
      ADD2, AND2: begin
        AC_LD   = 1'b1;
        AC_DATA = alu_y;
        state_d = FETCH1;
      end
      JMP1: begin
        PC_LD   = 1'b1;
        PC_DATA = ir_q[ADDR_W-1:0];
        state_d = FETCH1;
      end
      INC1: begin
        AC_INC  = 1'b1;
        state_d = FETCH1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, instruction and data registers; reset aborts any operation at once
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ir_q    <= '0;
      dr_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      dr_q    <= dr_d;
    end
  end

endmodule

// File: tb/tb_hardwired_ctrl.sv
// Bench for hardwired_ctrl: models the PC/AC counters (sampling on the
// falling edge) and a memory with per-address wait states. Expected control
// events are queued up front and consumed by a falling-edge monitor.
module tb_hardwired_ctrl;
  import cpu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       START = 1'b0;
  logic [5:0] PC_STATE;
  logic [8:0] AC_STATE;
  logic [7:0] MEM_DATA;
  logic       MEM_READY;
  logic [5:0] MEM_ADDR;
  logic       MEM_RD;
  logic       PC_LD, PC_INC, PC_CLR;
  logic [5:0] PC_DATA;
  logic       AC_LD, AC_INC, AC_CLR;
  logic [8:0] AC_DATA;
  logic       BUSY;

  hardwired_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .PC_STATE(PC_STATE), .AC_STATE(AC_STATE),
    .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
    .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_CLR(PC_CLR), .PC_DATA(PC_DATA),
    .AC_LD(AC_LD), .AC_INC(AC_INC), .AC_CLR(AC_CLR), .AC_DATA(AC_DATA),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counter models
  logic [5:0] pc_q;
  logic [8:0] ac_q;
  logic       poke_en = 1'b0;
  logic [8:0] poke_val = '0;
  assign PC_STATE = pc_q;
  assign AC_STATE = ac_q;

  always @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q <= '0;
      ac_q <= '0;
    end else begin
      if (PC_CLR)      pc_q <= '0;
      else if (PC_LD)  pc_q <= PC_DATA;
      else if (PC_INC) pc_q <= pc_q + 6'd1;
      if (AC_CLR)       ac_q <= '0;
      else if (AC_LD)   ac_q <= AC_DATA;
      else if (AC_INC)  ac_q <= ac_q + 9'd1;
      else if (poke_en) ac_q <= poke_val;
    end
  end

  // Memory model: reads at wait_addr are stalled for wait_n cycles
  logic [7:0] mem [64];
  logic       wait_en = 1'b0;
  logic [5:0] wait_addr = '0;
  int         wait_n = 0;
  int         wcnt = 0;
  assign MEM_READY = MEM_RD && !(wait_en && (MEM_ADDR == wait_addr) && (wcnt < wait_n));
  assign MEM_DATA  = MEM_READY ? mem[MEM_ADDR] : 8'h00;
  always @(posedge CLK) wcnt <= (MEM_RD && !MEM_READY) ? wcnt + 1 : 0;

  // Scoreboard
  localparam int K_CLR = 1, K_RD = 2, K_PCINC = 3, K_ACINC = 4, K_ACLD = 5, K_PCLD = 6;
  typedef struct { int kind; int val; } ev_t;
  ev_t sb[$];

  function automatic void exp_ev(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endfunction

  task automatic take(input int k, input int v);
    ev_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_event", k, 0);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", k, e.kind);
      chk($sformatf("ev%0d_value", k), v, e.val);
    end
  endtask

  // Monitor: cycle count, handshake hold, exclusivity, event matching
  int         cyc = 0;
  int         last_inc = 0;
  logic       prev_wait = 1'b0;
  logic [5:0] prev_addr = '0;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RST_N) begin
      chk("pc_ctl_excl", 32'($countones({PC_LD, PC_INC, PC_CLR}) <= 1), 1);
      chk("ac_ctl_excl", 32'($countones({AC_LD, AC_INC, AC_CLR}) <= 1), 1);
      if (prev_wait) begin
        chk("hold_rd", 32'(MEM_RD), 1);
        chk("hold_addr", 32'(MEM_ADDR), 32'(prev_addr));
      end
      if (MEM_RD && !MEM_READY) chk("no_ac_ctl_in_wait", 32'({AC_LD, AC_INC, AC_CLR}), 0);
      if (PC_CLR || AC_CLR) begin
        take(K_CLR, 32'({PC_CLR, AC_CLR}));
        last_inc = cyc;
      end
      if (MEM_RD && MEM_READY) take(K_RD, 32'(MEM_ADDR));
      if (PC_INC) begin
        take(K_PCINC, cyc - last_inc);
        last_inc = cyc;
      end
      if (AC_INC) take(K_ACINC, 32'(AC_STATE));
      if (AC_LD)  take(K_ACLD, 32'(AC_DATA));
      if (PC_LD)  take(K_PCLD, 32'(PC_DATA));
      prev_wait = MEM_RD && !MEM_READY;
      prev_addr = MEM_ADDR;
    end else begin
      prev_wait = 1'b0;
    end
  end

  task automatic wait_rd(input logic [5:0] addr, input logic done, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (MEM_RD && MEM_ADDR == addr && MEM_READY == done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic poke_ac(input logic [8:0] v);
    #1;
    poke_val = v;
    poke_en  = 1'b1;
    @(negedge CLK);
    #1;
    poke_en  = 1'b0;
  endtask

  task automatic check_all_zero(input string p);
    chk({p, "_mem_rd"},   32'(MEM_RD), 0);
    chk({p, "_mem_addr"}, 32'(MEM_ADDR), 0);
    chk({p, "_pc_ctl"},   32'({PC_LD, PC_INC, PC_CLR}), 0);
    chk({p, "_pc_data"},  32'(PC_DATA), 0);
    chk({p, "_ac_ctl"},   32'({AC_LD, AC_INC, AC_CLR}), 0);
    chk({p, "_ac_data"},  32'(AC_DATA), 0);
    chk({p, "_busy"},     32'(BUSY), 0);
    chk({p, "_state"},    32'(dut.state_q), 32'(IDLE));
    chk({p, "_ir"},       32'(dut.ir_q), 0);
    chk({p, "_dr"},       32'(dut.dr_q), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[6'h00] = 8'hC0;  // INC
    mem[6'h01] = 8'h05;  // ADD [5]
    mem[6'h02] = 8'h9F;  // JMP 0x1F
    mem[6'h05] = 8'h01;
    mem[6'h06] = 8'h3C;
    mem[6'h07] = 8'h10;
    mem[6'h1F] = 8'h46;  // AND [6]
    mem[6'h20] = 8'h07;  // ADD [7], operand read stalled 3 cycles
    mem[6'h21] = 8'hC0;  // INC
    mem[6'h22] = 8'hBF;  // JMP 0x3F
    mem[6'h3F] = 8'hC0;  // INC, then PC wraps to 0
    wait_en   = 1'b1;
    wait_addr = 6'h07;
    wait_n    = 3;

    // Program effects; PCINC value = cycles since previous FETCH2 (or CLEAR)
    exp_ev(K_CLR, 3);
    exp_ev(K_RD, 'h00); exp_ev(K_PCINC, 2); exp_ev(K_ACINC, 'h000);
    exp_ev(K_RD, 'h01); exp_ev(K_PCINC, 4); exp_ev(K_RD, 'h05); exp_ev(K_ACLD, 'h100);
    exp_ev(K_RD, 'h02); exp_ev(K_PCINC, 5); exp_ev(K_PCLD, 'h1F);
    exp_ev(K_RD, 'h1F); exp_ev(K_PCINC, 4); exp_ev(K_RD, 'h06); exp_ev(K_ACLD, 'h030);
    exp_ev(K_RD, 'h20); exp_ev(K_PCINC, 5); exp_ev(K_RD, 'h07); exp_ev(K_ACLD, 'h040);
    exp_ev(K_RD, 'h21); exp_ev(K_PCINC, 8); exp_ev(K_ACINC, 'h040);
    exp_ev(K_RD, 'h22); exp_ev(K_PCINC, 4); exp_ev(K_PCLD, 'h3F);
    exp_ev(K_RD, 'h3F); exp_ev(K_PCINC, 4); exp_ev(K_ACINC, 'h041);
    exp_ev(K_RD, 'h00); exp_ev(K_PCINC, 4); exp_ev(K_ACINC, 'h042);
    exp_ev(K_RD, 'h01); exp_ev(K_PCINC, 4);

    // Reset state
    #2 RST_N = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_before_start", 32'(BUSY), 0);
    #1 START = 1'b1;
    @(negedge CLK);
    #1 START = 1'b0;

    // INC at 0 done; AC preset for ADD 5 -> carry out
    wait_rd(6'h01, 1'b1, "fetch_01");
    chk("ac_after_inc", 32'(ac_q), 'h001);
    poke_ac(9'h0FF);

    // START while busy must have no effect
    wait_rd(6'h02, 1'b1, "fetch_02");
    chk("ac_after_add_carry", 32'(ac_q), 'h100);
    #1 START = 1'b1;
    @(negedge CLK);
    #1 START = 1'b0;

    // After JMP, AND at 0x1F with AC preset to 0x0F0
    wait_rd(6'h1F, 1'b1, "fetch_1f");
    poke_ac(9'h0F0);
    wait_rd(6'h20, 1'b1, "fetch_20");
    chk("ac_after_and", 32'(ac_q), 'h030);
    wait_rd(6'h21, 1'b1, "fetch_21");
    chk("ac_after_add_wait", 32'(ac_q), 'h040);

    // PC wrap from 0x3F back to 0, then stall ADD1 forever and reset
    wait_rd(6'h00, 1'b1, "fetch_wrap_00");
    wait_addr = 6'h05;
    wait_n    = 1000;
    wait_rd(6'h01, 1'b1, "fetch_01_again");
    chk("ac_after_wrap", 32'(ac_q), 'h043);
    wait_rd(6'h05, 1'b0, "stall_add1");
    repeat (2) @(negedge CLK);
    chk("add1_still_reading", 32'(MEM_RD), 1);
    chk("sb_drained", sb.size(), 0);
    #2 RST_N = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge CLK);
    #1 RST_N   = 1'b1;
    wait_en = 1'b0;
    repeat (4) @(negedge CLK);
    chk("idle_after_reset_busy", 32'(BUSY), 0);
    chk("idle_after_reset_state", 32'(dut.state_q), 32'(IDLE));
    chk("idle_after_reset_rd", 32'(MEM_RD), 0);
    chk("sb_empty_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
